// File: rtl/des_pkg.sv
// des_pkg: types and widths shared by the DES input loader, des_controller
// and the DES datapath.
//   asm_state_t : block-assembly FSM states
//   DES_BLOCK_W : DES block width in bits
//   DES_BYTE_W  : width of one received byte
package des_pkg;

  localparam int DES_BLOCK_W = 64;
  localparam int DES_BYTE_W  = 8;

  typedef enum logic {
    ASM_FILL  = 1'b0,
    ASM_STALL = 1'b1
  } asm_state_t;

endpackage

// File: rtl/des_block_loader.sv
// des_block_loader: packs USB receive bytes big-endian into DES blocks and
// holds each finished block for des_controller. Two registers are used. One
// assembles the next block while the other holds the current block.
// Ports:
//   clk, n_rst            clock, synchronous active-low reset
//   byte_in/byte_valid    incoming byte and its qualifier
//   byte_ready            byte accepted this cycle (state only)
//   encrypt_in            mode bit, sampled with the first byte of a block
//   clear                 synchronous flush of both registers
//   load                  controller takes the held block (1-cycle strobe)
//   full                  hold register valid
//   block_out             held block
//   encrypt_sync          mode of the held block
//   overrun               1-cycle pulse after a byte offered while stalled
//   fill_count            bytes currently in the assembly register (0..8)
module des_block_loader
  import des_pkg::*;
#(
  parameter int BLOCK_BYTES = 8
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [DES_BYTE_W-1:0]   byte_in,
  input  logic                    byte_valid,
  output logic                    byte_ready,
  input  logic                    encrypt_in,
  input  logic                    clear,
  input  logic                    load,
  output logic                    full,
  output logic [BLOCK_BYTES*8-1:0] block_out,
  output logic                    encrypt_sync,
  output logic                    overrun,
  output logic [3:0]              fill_count
);

  localparam int BW = BLOCK_BYTES * 8;
  localparam logic [3:0] LAST_IDX = 4'(BLOCK_BYTES - 1);
  localparam logic [3:0] FULL_CNT = 4'(BLOCK_BYTES);

  asm_state_t        asm_state;
  logic [BW-1:0]     asm_reg;
  logic              asm_enc_reg;

  logic              accept;
  logic [BW-1:0]     asm_word;
  logic              asm_enc;

  // Ready depends on state only, so the upstream handshake never sees a
  // combinational path from load or byte_valid.
  assign byte_ready = (asm_state == ASM_FILL);
  assign accept     = byte_valid && byte_ready;

  // Word and mode as they would look with the current byte inserted. The
  // first byte of a block captures the mode for the whole block.
  assign asm_word = {asm_reg[BW-DES_BYTE_W-1:0], byte_in};
  assign asm_enc  = (fill_count == 4'd0) ? encrypt_in : asm_enc_reg;

  always_ff @(posedge clk) begin
    if (!n_rst || clear) begin
      asm_state    <= ASM_FILL;
      asm_reg      <= '0;
      asm_enc_reg  <= 1'b0;
      fill_count   <= 4'd0;
      full         <= 1'b0;
      block_out    <= '0;
      encrypt_sync <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= byte_valid && !byte_ready;

      case (asm_state)
        ASM_FILL: begin
          if (accept && fill_count == LAST_IDX) begin
            if (!full || load) begin
              // Hold is free now (or is freed by this load): the completed
              // word goes straight into hold and no cycle is lost.
              block_out    <= asm_word;
              encrypt_sync <= asm_enc;
              full         <= 1'b1;
              fill_count   <= 4'd0;
            end else begin
              asm_reg     <= asm_word;
              asm_enc_reg <= asm_enc;
              fill_count  <= FULL_CNT;
              asm_state   <= ASM_STALL;
            end
          end else begin
            if (accept) begin
              asm_reg     <= asm_word;
              asm_enc_reg <= asm_enc;
              fill_count  <= fill_count + 4'd1;
            end
            // A load on an empty hold simply leaves full at 0.
            if (load) begin
              full <= 1'b0;
            end
          end
        end

        ASM_STALL: begin
          // Stall implies hold is full; load swaps the waiting block in.
          if (load) begin
            block_out    <= asm_reg;
            encrypt_sync <= asm_enc_reg;
            full         <= 1'b1;
            fill_count   <= 4'd0;
            asm_state    <= ASM_FILL;
          end
        end

        default: asm_state <= ASM_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_des_block_loader.sv
module tb_des_block_loader;
  import des_pkg::*;

  logic        clk;
  logic        n_rst;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        encrypt_in;
  logic        clear;
  logic        load;
  logic        full;
  logic [63:0] block_out;
  logic        encrypt_sync;
  logic        overrun;
  logic [3:0]  fill_count;

  des_block_loader #(.BLOCK_BYTES(8)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .encrypt_in   (encrypt_in),
    .clear        (clear),
    .load         (load),
    .full         (full),
    .block_out    (block_out),
    .encrypt_sync (encrypt_sync),
    .overrun      (overrun),
    .fill_count   (fill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rn;
    logic        clr;
    logic        v;
    logic [7:0]  b;
    logic        e;
    logic        ld;
    logic        x_full;
    logic [63:0] x_blk;
    logic        x_enc;
    logic        x_rdy;
    logic        x_ovr;
    logic [3:0]  x_fill;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  localparam logic [63:0] B1 = 64'h0102030405060708;
  localparam logic [63:0] B2 = 64'h1112131415161718;
  localparam logic [63:0] B3 = 64'h2122232425262728;
  localparam logic [63:0] B4 = 64'h3132333435363738;
  localparam logic [63:0] B5 = 64'h5152535455565758;
  localparam logic [63:0] B7 = 64'h7172737475767778;
  localparam logic [63:0] B8 = 64'h8182838485868788;

  task automatic add(input logic rn, input logic clr, input logic v,
                     input logic [7:0] b, input logic e, input logic ld,
                     input logic xf, input logic [63:0] xb, input logic xe,
                     input logic xr, input logic xo, input logic [3:0] xfl);
    vec_t t;
    t.rn = rn; t.clr = clr; t.v = v; t.b = b; t.e = e; t.ld = ld;
    t.x_full = xf; t.x_blk = xb; t.x_enc = xe; t.x_rdy = xr;
    t.x_ovr = xo; t.x_fill = xfl;
    vecs.push_back(t);
  endtask

  // Drive one cycle of inputs, then compare all outputs 1 time unit after
  // the rising edge.
  task automatic step(input string name, input vec_t t);
    n_rst      = t.rn;
    clear      = t.clr;
    byte_valid = t.v;
    byte_in    = t.b;
    encrypt_in = t.e;
    load       = t.ld;
    @(posedge clk);
    #1;
    n_vec++;
    if (full !== t.x_full || block_out !== t.x_blk ||
        encrypt_sync !== t.x_enc || byte_ready !== t.x_rdy ||
        overrun !== t.x_ovr || fill_count !== t.x_fill) begin
      n_miss++;
      $display("FAIL %s: got full=%0b blk=%h enc=%0b rdy=%0b ovr=%0b fill=%0d, want full=%0b blk=%h enc=%0b rdy=%0b ovr=%0b fill=%0d",
               name, full, block_out, encrypt_sync, byte_ready, overrun, fill_count,
               t.x_full, t.x_blk, t.x_enc, t.x_rdy, t.x_ovr, t.x_fill);
    end else begin
      $display("ok   %s: full=%0b blk=%h enc=%0b rdy=%0b ovr=%0b fill=%0d",
               name, full, block_out, encrypt_sync, byte_ready, overrun, fill_count);
    end
  endtask

  initial begin
    vec_t t;
    int   waited;
    n_rst = 1'b0; clear = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    encrypt_in = 1'b0; load = 1'b0;
    @(negedge clk);

    // ---- table ----
    add(0,0,0,8'h00,0,0, 0,64'h0,0,1,0,4'd0);                      // reset
    for (int i = 1; i <= 8; i++)                                     // block 1
      add(1,0,1,8'(i),1,0, i == 8, (i == 8) ? B1 : 64'h0, i == 8, 1, 0,
          (i == 8) ? 4'd0 : 4'(i));
    for (int i = 1; i <= 8; i++)                                     // block 2 stalls
      add(1,0,1,8'(16+i),1,0, 1,B1,1, i < 8, 0, 4'(i));
    add(1,0,1,8'h99,1,0, 1,B1,1,0,1,4'd8);                           // overrun, dropped
    add(1,0,0,8'h00,0,0, 1,B1,1,0,0,4'd8);                           // pulse ends
    add(1,0,0,8'h00,0,1, 1,B2,1,1,0,4'd0);                           // load swaps in B2
    add(1,0,1,8'h21,1,0, 1,B2,1,1,0,4'd1);                           // block 3, mode=1
    for (int i = 2; i <= 7; i++)
      add(1,0,1,8'(32+i),0,0, 1,B2,1,1,0,4'(i));                     // mode toggled to 0
    add(1,0,1,8'h28,0,1, 1,B3,1,1,0,4'd0);                           // 8th byte + load
    add(1,0,0,8'h00,0,1, 0,B3,1,1,0,4'd0);                           // load empties hold
    for (int i = 1; i <= 8; i++)                                     // block 4, mode=0
      add(1,0,1,8'(48+i),0,0, i == 8, (i == 8) ? B4 : B3, (i == 8) ? 1'b0 : 1'b1,
          1, 0, (i == 8) ? 4'd0 : 4'(i));
    add(1,0,0,8'h00,0,1, 0,B4,0,1,0,4'd0);
    for (int i = 1; i <= 5; i++)                                     // partial, then clear
      add(1,0,1,8'(64+i),1,0, 0,B4,0,1,0,4'(i));
    add(1,1,1,8'h46,1,1, 0,64'h0,0,1,0,4'd0);                        // clear wins
    for (int i = 1; i <= 8; i++)                                     // fresh block 5
      add(1,0,1,8'(80+i),1,0, i == 8, (i == 8) ? B5 : 64'h0, i == 8, 1, 0,
          (i == 8) ? 4'd0 : 4'(i));
    add(1,0,0,8'h00,0,1, 0,B5,1,1,0,4'd0);                           // load
    add(1,0,0,8'h00,0,1, 0,B5,1,1,0,4'd0);                           // load with full=0
    for (int i = 1; i <= 3; i++)                                     // partial, then reset
      add(1,0,1,8'(96+i),1,0, 0,B5,1,1,0,4'(i));
    add(0,0,1,8'h64,1,0, 0,64'h0,0,1,0,4'd0);
    for (int i = 1; i <= 8; i++)                                     // block 7, mode=0
      add(1,0,1,8'(112+i),0,0, i == 8, (i == 8) ? B7 : 64'h0, 0, 1, 0,
          (i == 8) ? 4'd0 : 4'(i));

    foreach (vecs[k]) step($sformatf("vec%0d", k), vecs[k]);

    // ---- hand sequence: stall, then load with a byte pending ----
    n_rst = 1'b1; clear = 1'b0; load = 1'b0; byte_valid = 1'b1; encrypt_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      byte_in = 8'(128+i);
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    waited = 0;
    while (byte_ready !== 1'b0 && waited < 4) begin
      @(posedge clk); #1;
      waited++;
    end
    n_vec++;
    if (byte_ready !== 1'b0 || fill_count !== 4'd8) begin
      n_miss++;
      $display("FAIL stall_wait: rdy=%0b fill=%0d, want rdy=0 fill=8", byte_ready, fill_count);
    end else begin
      $display("ok   stall_wait: rdy=0 fill=8");
    end
    // byte offered in the same cycle as load while stalled: dropped
    t.rn = 1; t.clr = 0; t.v = 1; t.b = 8'h90; t.e = 0; t.ld = 1;
    t.x_full = 1; t.x_blk = B8; t.x_enc = 1; t.x_rdy = 1; t.x_ovr = 1; t.x_fill = 4'd0;
    step("stall_load_drop", t);
    // same byte held: now accepted as first byte of the next block
    t.ld = 0; t.x_ovr = 0; t.x_fill = 4'd1;
    step("after_stall_accept", t);
    t.v = 0; t.clr = 1; t.x_full = 0; t.x_blk = 64'h0; t.x_enc = 0; t.x_fill = 4'd0;
    step("final_clear", t);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/des_block_loader.md
# des_block_loader

Input staging stage directly upstream of `des_controller`. Assembles bytes from the USB receive path into 64-bit DES blocks and presents each block with a level `full` to the controller. Holds the block until the controller's one-cycle `load` strobe. Double-buffered: the next block assembles while DES rounds run on the current one.

## Interface
Parameters:
- `BLOCK_BYTES`, 8, bytes per block; fixes block width at `BLOCK_BYTES*8`.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `n_rst`  in  1  reset, synchronous and active-low.
- `byte_in`  in  8  received data byte.
- `byte_valid`  in  1  `byte_in` is valid this cycle.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `encrypt_in`  in  1  mode from host: 1 = encrypt, 0 = decrypt; sampled with first byte of each block.
- `clear`  in  1  synchronous flush of both buffers (USB bus reset / abort).
- `load`  in  1  controller consumes held block (one-cycle strobe in its LOAD state).
- `full`  out  1  holding register contains a valid block.
- `block_out`  out  64  held block.
- `encrypt_sync`  out  1  mode bit belonging to the held block.
- `overrun`  out  1  one-cycle pulse: `byte_valid` while `byte_ready`=0.
- `fill_count`  out  4  bytes in assembly register, 0..8.

## Operation
- Byte accepted on `byte_valid && byte_ready`. Big-endian packing: first byte to [63:56], eighth byte to [7:0]. Implemented as shift-left-by-8 insert at LSB.
- Assembly FSM (`asm_state`):
  - ASM_FILL: `byte_ready`=1; `fill_count` increments per accepted byte.
  - On the 8th accepted byte: if hold is empty or `load`=1 this cycle, the completed word (including that byte) moves into hold at the same edge and `fill_count` returns to 0. Otherwise go to ASM_STALL with `fill_count`=8.
  - ASM_STALL: `byte_ready`=0. On `load`, assembly moves into hold, `full` stays 1, `fill_count`=0, return to ASM_FILL.
- Mode: `encrypt_in` is latched when `fill_count`=0 and a byte is accepted. It travels with the block into hold and drives `encrypt_sync`. Mode changes mid-block have no effect on that block.
- Hold: `full` set on transfer, cleared on `load` unless a transfer happens the same cycle. `block_out` and `encrypt_sync` stay stable while `full`=1.
- `load` while `full`=0: ignored, no state change.
- `clear`: same effect as reset on all state except outputs already sampled by the controller. Priority: reset > `clear` > `load`/transfer > byte accept.
- `overrun`: the byte is dropped; no other state changes.

## Timing
- Reset / `clear` values: `full`=0, `block_out`=0, `encrypt_sync`=0, `fill_count`=0, `byte_ready`=1, `overrun`=0, `asm_state`=ASM_FILL.
- `byte_ready` is combinational from state only (=1 iff ASM_FILL). It does not depend on `byte_valid` or `load`.
- Latency, 8th byte to `full`: 1 cycle (registered).
- `load` to `full`=0: 1 cycle. Back-to-back with a stalled block: `full` stays 1 and `block_out` changes on the edge after `load`.
- Sustained throughput: 1 byte/cycle while hold is free. A block whose 8th byte arrives with `load` in the same cycle loses no cycle.
- Reset or `clear` mid-block discards partial and held data. The next accepted byte starts a new block.

## Structure
- Shared package `des_pkg`:
  - `asm_state_t` enum {ASM_FILL, ASM_STALL}.
  - `DES_BLOCK_W`=64 and `DES_BYTE_W`=8 constants, shared with `des_controller` and the datapath.
- No sub-module. Single module with an assembly register, a hold register, and the two-state FSM.

## Test plan
- Reset, then 8 bytes 0x01..0x08 on consecutive cycles with `encrypt_in`=1 → one cycle after the last byte, `full`=1, `block_out`=0x0102030405060708, `encrypt_sync`=1, `fill_count`=0.
- Hold full, 8 more bytes 0x11..0x18, no `load` → `byte_ready`=0 after the 8th, `fill_count`=8. A 9th `byte_valid` gives `overrun` pulse; the byte is dropped. `load` → next cycle `block_out`=0x1112131415161718, `full`=1, `byte_ready`=1.
- `encrypt_in` toggles 1→0 after the first byte of a block → `encrypt_sync`=1 for that block; next block started with `encrypt_in`=0 gives `encrypt_sync`=0.
- 8th byte and `load` in the same cycle with hold full → no stall, new block in hold next cycle, `full` stays 1.
- 5 bytes accepted, then `clear` (or `n_rst`=0) for one cycle → `fill_count`=0, `full`=0. The following 8 bytes form a fresh block with no residue from the first 5.
- `load` strobe with `full`=0 → no output change; a subsequent block assembles normally.
